// File: rtl/fetch_decoder.sv
// rtl/fetch_decoder.sv - Z80 opcode-fetch decoder tracking ISR entry and JP/JP (HL) completion.
// Bus strobes are registered, each fetch/read cycle is held and committed once when it ends.
module fetch_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        rd_n,
  input  logic [15:0] addr,
  input  logic [7:0]  data,
  input  logic        trap_state,
  output logic        new_isr,
  output logic        last_isr_jmp,
  output logic [15:0] jmp_target,
  output logic        jmp_target_valid,
  output logic [7:0]  isr_len
);

  typedef enum logic [2:0] {S_IDLE, S_PFX_IX, S_PFX_CB, S_PFX_ED, S_JP_LO, S_JP_HI} state_t;
  typedef enum logic [1:0] {K_NONE, K_FETCH, K_READ} kind_t;

  localparam logic [15:0] ISR_ADDR = 16'h0066;

  logic        r_m1_n, r_mreq_n, r_rd_n;
  logic [15:0] r_addr;
  logic [7:0]  r_data;
  kind_t       r_hold_kind;
  logic [15:0] r_hold_addr;
  logic [7:0]  r_hold_data;
  logic [7:0]  r_jp_lo;
  state_t      r_state;
  state_t      w_next;
  kind_t       w_kind;
  logic        w_commit, w_op_commit, w_rd_commit;
  logic        w_jmp_done, w_jmp_nn, w_lo_latch;
  logic        r_new_isr, r_last_isr_jmp, r_jmp_target_valid;
  logic [15:0] r_jmp_target;
  logic [7:0]  r_isr_len;

  // Strobes reset to the inactive level so reset release never looks like a bus cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m1_n   <= 1'b1;
      r_mreq_n <= 1'b1;
      r_rd_n   <= 1'b1;
      r_addr   <= '0;
      r_data   <= '0;
    end else begin
      r_m1_n   <= m1_n;
      r_mreq_n <= mreq_n;
      r_rd_n   <= rd_n;
      r_addr   <= addr;
      r_data   <= data;
    end
  end

  always_comb begin
    w_kind = K_NONE;
    if (!r_mreq_n && !r_rd_n) w_kind = r_m1_n ? K_READ : K_FETCH;
  end

  assign w_commit    = (r_hold_kind != K_NONE) && (w_kind != r_hold_kind);
  assign w_op_commit = w_commit && (r_hold_kind == K_FETCH);
  assign w_rd_commit = w_commit && (r_hold_kind == K_READ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_kind <= K_NONE;
      r_hold_addr <= '0;
      r_hold_data <= '0;
      r_jp_lo     <= '0;
      r_state     <= S_IDLE;
    end else begin
      r_hold_kind <= w_kind;
      if (w_kind != K_NONE) begin
        r_hold_addr <= r_addr;
        r_hold_data <= r_data;
      end
      if (w_lo_latch) r_jp_lo <= r_hold_data;
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_jmp_done = 1'b0;
    w_jmp_nn   = 1'b0;
    w_lo_latch = 1'b0;
    if (w_op_commit) begin
      if (r_state == S_PFX_CB || r_state == S_PFX_ED) begin
        w_next = S_IDLE;
      end else begin
        case (r_hold_data)
          8'hC3:        w_next = S_JP_LO;
          8'hE9: begin
            w_next     = S_IDLE;
            w_jmp_done = 1'b1;
          end
          8'hDD, 8'hFD: w_next = S_PFX_IX;
          // DD CB d op: displacement and op arrive as plain reads and are ignored from IDLE.
          8'hCB:        w_next = (r_state == S_PFX_IX) ? S_IDLE : S_PFX_CB;
          8'hED:        w_next = S_PFX_ED;
          default:      w_next = S_IDLE;
        endcase
      end
    end else if (w_rd_commit) begin
      if (r_state == S_JP_LO) begin
        w_lo_latch = 1'b1;
        w_next     = S_JP_HI;
      end else if (r_state == S_JP_HI) begin
        w_jmp_done = 1'b1;
        w_jmp_nn   = 1'b1;
        w_next     = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_new_isr          <= 1'b0;
      r_last_isr_jmp     <= 1'b0;
      r_jmp_target       <= '0;
      r_jmp_target_valid <= 1'b0;
      r_isr_len          <= '0;
    end else begin
      if (w_op_commit) begin
        r_new_isr <= (r_hold_addr == ISR_ADDR);
        if (r_hold_addr == ISR_ADDR) r_isr_len <= 8'd1;
        else if (r_isr_len != 8'hFF) r_isr_len <= r_isr_len + 8'd1;
        if (!w_jmp_done) r_last_isr_jmp <= 1'b0;
      end
      if (w_jmp_done) begin
        r_last_isr_jmp     <= trap_state;
        r_jmp_target_valid <= w_jmp_nn;
        if (w_jmp_nn) r_jmp_target <= {r_hold_data, r_jp_lo};
      end
    end
  end

  assign new_isr          = r_new_isr;
  assign last_isr_jmp     = r_last_isr_jmp;
  assign jmp_target       = r_jmp_target;
  assign jmp_target_valid = r_jmp_target_valid;
  assign isr_len          = r_isr_len;

endmodule

// File: doc/fetch_decoder.md
FETCH_DECODER -- requirements
Module: fetch_decoder

Interface
REQ-001 SHALL have ports: clk  in  1  system clock; all bus inputs sampled on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous reset, active-high.
REQ-003 SHALL have ports: m1_n in 1, mreq_n in 1, rd_n in 1  raw Z80 bus strobes, active-low.
REQ-004 SHALL have ports: addr  in  16  Z80 address bus; data  in  8  Z80 data bus.
REQ-005 SHALL have port: trap_state  in  1  current trap state from the trap/mode logic.
REQ-006 SHALL have ports: new_isr  out  1  last committed opcode fetch was from 0x0066.
REQ-007 SHALL have ports: last_isr_jmp  out  1  unconditional jump completed while trapped.
REQ-008 SHALL have ports: jmp_target out 16 captured JP destination; jmp_target_valid out 1 target known.
REQ-009 SHALL have port: isr_len  out  8  opcode fetches since last new_isr, saturating.

Function
REQ-010 SHALL register m1_n, mreq_n, rd_n, addr, data every clk; all decode uses registered copies only.
REQ-011 SHALL classify a sampled cycle as fetch-active when m1_n=0, mreq_n=0, rd_n=0; as read-active when m1_n=1, mreq_n=0, rd_n=0; refresh (mreq_n=0, rd_n=1) and I/O and interrupt-ack cycles are ignored.
REQ-012 SHALL hold the latest data/addr while a cycle is active and commit it on the first sample where that cycle is no longer active (opcode commit or operand commit), exactly one commit per bus cycle.
REQ-013 SHALL run a decode FSM with states IDLE, PFX_IX (after DD/FD), PFX_CB, PFX_ED, JP_LO, JP_HI; only commits change state.
REQ-014 IDLE/PFX_IX opcode commit: C3 -> JP_LO; E9 -> jump complete, target unknown, -> IDLE; DD/FD -> PFX_IX; CB -> PFX_CB; ED -> PFX_ED; other -> IDLE.
REQ-015 PFX_CB or PFX_ED opcode commit: SHALL return to IDLE with no jump, regardless of value (CB C3, ED E9 are not jumps).
REQ-016 PFX_IX then CB: SHALL return to IDLE and ignore the following two operand reads.
REQ-017 JP_LO operand commit: latch low byte -> JP_HI; JP_HI operand commit: latch high byte, jump complete with target {hi,lo} -> IDLE.
REQ-018 Opcode commit while in JP_LO/JP_HI: SHALL abandon the jump and decode that opcode as from IDLE.
REQ-019 Jump complete: SHALL set last_isr_jmp=1 only if trap_state=1 at the completing commit; SHALL update jmp_target and set jmp_target_valid=1 (JP nn) or 0 (E9/DD E9/FD E9, jmp_target unchanged).
REQ-020 last_isr_jmp SHALL clear on the next opcode commit that does not itself complete a jump.
REQ-021 new_isr SHALL be set by an opcode commit with addr=0x0066 and cleared by any other opcode commit, in the cycle after the commit.
REQ-022 isr_len SHALL reset to 1 on an opcode commit at 0x0066, increment by 1 on every other opcode commit, and saturate at 255.
REQ-023 All outputs SHALL be registered; output update latency is one clk after the commit sample.
REQ-024 Simultaneous fetch commit at 0x0066 and jump completion (E9 at 0x0066) SHALL set both new_isr and the jump outputs.

Reset
REQ-025 rst=1 SHALL asynchronously force FSM=IDLE, new_isr=0, last_isr_jmp=0, jmp_target=0x0000, jmp_target_valid=0, isr_len=0, and clear all bus-sample and hold registers.
REQ-026 rst asserted mid-cycle SHALL discard any pending commit; the bus cycle in progress at deassertion SHALL commit only if it is still active for one sample after deassertion.

Verification
REQ-027 Fetch 0x0066 data 0xF5 -> new_isr=1, isr_len=1 one clk after commit; next fetch at 0x0067 -> new_isr=0, isr_len=2.
REQ-028 trap_state=1, fetch C3, reads 0x34, 0x12 -> last_isr_jmp=1, jmp_target=0x1234, jmp_target_valid=1; next fetch 0x00 -> last_isr_jmp=0.
REQ-029 trap_state=1, fetch CB then C3, then fetch DD then E9 -> no jump after CB C3; after DD E9 last_isr_jmp=1, jmp_target_valid=0, jmp_target unchanged.
REQ-030 trap_state=0, C3 0x00 0x80 -> last_isr_jmp=0, jmp_target=0x8000, jmp_target_valid=1.
REQ-031 C3, read 0x10, then opcode fetch 0x00 -> FSM=IDLE, no jump; refresh cycles (rd_n=1) between fetches -> no commit, isr_len unchanged; 300 fetches after 0x0066 -> isr_len=255.
REQ-032 rst pulsed during JP_HI read -> all outputs at reset values, subsequent read produces no jump.
